// File: rtl/udma_cfg_master.sv
// APB slave that forwards each access as one request on a one-hot valid/ready config bus.
// Out-of-range targets and responders that never answer complete with pslverr.
module udma_cfg_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_TARGETS      = 8,
  parameter int TIMEOUT        = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [APB_ADDR_WIDTH-1:0] apb_paddr_i,
  input  logic [31:0]               apb_pwdata_i,
  input  logic                      apb_pwrite_i,
  input  logic                      apb_psel_i,
  input  logic                      apb_penable_i,
  output logic [31:0]               apb_prdata_o,
  output logic                      apb_pready_o,
  output logic                      apb_pslverr_o,
  output logic [31:0]               cfg_data_o,
  output logic [4:0]                cfg_addr_o,
  output logic                      cfg_rwn_o,
  output logic [N_TARGETS-1:0]      cfg_valid_o,
  input  logic [N_TARGETS*32-1:0]   cfg_data_i,
  input  logic [N_TARGETS-1:0]      cfg_ready_i
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [4:0] N_TGT = 5'(N_TARGETS);
  localparam logic [APB_ADDR_WIDTH-1:0] DEC_MASK = APB_ADDR_WIDTH'(11'h7FC);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rdata;
  logic             error;

  logic        access;
  logic [3:0]  idx_dec;
  logic        idx_ok;
  logic        tgt_ready;
  logic [31:0] tgt_rdata;
  logic        unused_paddr_bits;

  assign access    = apb_psel_i & apb_penable_i;
  assign idx_dec   = apb_paddr_i[10:7];
  assign idx_ok    = ({1'b0, idx_dec} < N_TGT);
  assign unused_paddr_bits = ^(apb_paddr_i & ~DEC_MASK);

  // The registered one-hot valid doubles as the selected target index.
  assign tgt_ready = |(cfg_ready_i & cfg_valid_o);

  always_comb begin
    tgt_rdata = '0;
    for (int i = 0; i < N_TARGETS; i++)
      if (cfg_valid_o[i]) tgt_rdata = cfg_data_i[i*32 +: 32];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cfg_valid_o <= '0;
      cfg_data_o  <= '0;
      cfg_addr_o  <= '0;
      cfg_rwn_o   <= 1'b1;
      cnt         <= '0;
      rdata       <= '0;
      error       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (idx_ok) begin
              cfg_valid_o <= N_TARGETS'(1) << idx_dec;
              cfg_addr_o  <= apb_paddr_i[6:2];
              cfg_data_o  <= apb_pwdata_i;
              cfg_rwn_o   <= ~apb_pwrite_i;
              cnt         <= '0;
              state       <= REQ;
            end else begin
              error <= 1'b1;
              rdata <= '0;
              state <= DONE;
            end
          end
        end
        REQ: begin
          if (tgt_ready) begin
            cfg_valid_o <= '0;
            rdata       <= cfg_rwn_o ? tgt_rdata : 32'h0;
            error       <= 1'b0;
            state       <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
            cfg_valid_o <= '0;
            rdata       <= '0;
            error       <= 1'b1;
            state       <= DONE;
          end else if (cnt != CNT_MAX) begin
            // Saturate so an unbounded wait never wraps the counter.
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign apb_pready_o  = (state == DONE);
  assign apb_pslverr_o = (state == DONE) & error;
  assign apb_prdata_o  = (state == DONE) ? rdata : 32'h0;

endmodule

// File: tb/tb_udma_cfg_master.sv
// Self-checking bench for udma_cfg_master: scoreboard of APB completions plus per-scenario cfg-bus checks.
module tb_udma_cfg_master;

  localparam int AW = 12;
  localparam int NT = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] paddr = '0;
  logic [31:0]   pwdata = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [31:0]   apb_prdata_o;
  logic          apb_pready_o;
  logic          apb_pslverr_o;
  logic [31:0]   cfg_data_o;
  logic [4:0]    cfg_addr_o;
  logic          cfg_rwn_o;
  logic [NT-1:0] cfg_valid_o;
  logic [NT*32-1:0] cfg_data_flat;
  logic [NT-1:0] cfg_ready;

  logic [31:0] resp_data [NT];
  int          ready_wait = 0;
  logic        ready_never = 1'b0;
  int          vcnt;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_compared = 0;
  int n_mismatched = 0;

  udma_cfg_master #(.APB_ADDR_WIDTH(AW), .N_TARGETS(NT), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .apb_paddr_i(paddr), .apb_pwdata_i(pwdata), .apb_pwrite_i(pwrite),
    .apb_psel_i(psel), .apb_penable_i(penable),
    .apb_prdata_o(apb_prdata_o), .apb_pready_o(apb_pready_o), .apb_pslverr_o(apb_pslverr_o),
    .cfg_data_o(cfg_data_o), .cfg_addr_o(cfg_addr_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o), .cfg_data_i(cfg_data_flat), .cfg_ready_i(cfg_ready)
  );

  always #5 clk = ~clk;

  // Responder model: answers after ready_wait cycles of valid, or never.
  always @(posedge clk or posedge rst) begin
    if (rst) vcnt <= 0;
    else vcnt <= (cfg_valid_o != 0) ? vcnt + 1 : 0;
  end

  assign cfg_ready = (ready_never || vcnt < ready_wait) ? '0 : cfg_valid_o;

  always_comb begin
    cfg_data_flat = '0;
    for (int i = 0; i < NT; i++) cfg_data_flat[i*32 +: 32] = resp_data[i];
  end

  // Scoreboard: every pready pops the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && apb_pready_o) begin
      if (sb.size() == 0) begin
        n_compared++; n_mismatched++;
        $display("[TB] FAIL sb_unexpected_pready: got pready=1 want no pending transfer");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_compared++;
        if (apb_prdata_o !== e.rdata) begin n_mismatched++; $display("[TB] FAIL sb_prdata: got %h want %h", apb_prdata_o, e.rdata); end
        n_compared++;
        if (apb_pslverr_o !== e.err) begin n_mismatched++; $display("[TB] FAIL sb_pslverr: got %b want %b", apb_pslverr_o, e.err); end
      end
    end
  end

  task automatic push_exp(input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  // Setup then access phase; observe until pready, then release the bus.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic wr,
                          output int vcyc, output logic [NT-1:0] vseen, output int lat,
                          output logic [4:0] vaddr, output logic vrwn, output logic [31:0] vdata);
    vcyc = 0; vseen = '0; lat = 0; vaddr = '0; vrwn = 1'b0; vdata = '0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwdata = wdata; pwrite = wr;
    @(posedge clk); #1;
    penable = 1'b1;
    forever begin
      @(negedge clk);
      if (cfg_valid_o != 0) begin
        if (vcyc == 0) begin vaddr = cfg_addr_o; vrwn = cfg_rwn_o; vdata = cfg_data_o; end
        vcyc++;
        vseen |= cfg_valid_o;
      end
      if (apb_pready_o) break;
      lat++;
      if (lat > 200) break;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared++; if (cfg_valid_o !== '0) begin n_mismatched++; $display("[TB] FAIL rst_valid: got %h want 00", cfg_valid_o); end
    n_compared++; if (cfg_data_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_data: got %h want 0", cfg_data_o); end
    n_compared++; if (cfg_addr_o !== 5'h0) begin n_mismatched++; $display("[TB] FAIL rst_addr: got %h want 0", cfg_addr_o); end
    n_compared++; if (cfg_rwn_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_rwn: got %b want 1", cfg_rwn_o); end
    n_compared++; if (apb_pready_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_pready: got %b want 0", apb_pready_o); end
    n_compared++; if (apb_pslverr_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_pslverr: got %b want 0", apb_pslverr_o); end
    n_compared++; if (apb_prdata_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_prdata: got %h want 0", apb_prdata_o); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write();
    int vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    ready_wait = 0; ready_never = 1'b0;
    push_exp(32'h0, 1'b0);
    apb_xfer(12'h104, 32'hA5A5_0F0F, 1'b1, vc, vs, lat, va, vr, vd);
    n_compared++; if (vs !== 8'h04) begin n_mismatched++; $display("[TB] FAIL wr_valid_bits: got %h want 04", vs); end
    n_compared++; if (vc !== 1) begin n_mismatched++; $display("[TB] FAIL wr_valid_cycles: got %0d want 1", vc); end
    n_compared++; if (va !== 5'd1) begin n_mismatched++; $display("[TB] FAIL wr_addr: got %0d want 1", va); end
    n_compared++; if (vr !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wr_rwn: got %b want 0", vr); end
    n_compared++; if (vd !== 32'hA5A5_0F0F) begin n_mismatched++; $display("[TB] FAIL wr_data: got %h want a5a50f0f", vd); end
    n_compared++; if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL wr_latency: got %0d want 2", lat); end
    @(negedge clk);
    n_compared++; if (cfg_data_o !== 32'hA5A5_0F0F) begin n_mismatched++; $display("[TB] FAIL hold_data: got %h want a5a50f0f", cfg_data_o); end
    n_compared++; if (cfg_addr_o !== 5'd1) begin n_mismatched++; $display("[TB] FAIL hold_addr: got %0d want 1", cfg_addr_o); end
  endtask

  task automatic test_read_wait();
    int vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    ready_wait = 3; ready_never = 1'b0;
    resp_data[0] = 32'h0000_1234;
    push_exp(32'h0000_1234, 1'b0);
    apb_xfer(12'h010, 32'hFFFF_FFFF, 1'b0, vc, vs, lat, va, vr, vd);
    n_compared++; if (vs !== 8'h01) begin n_mismatched++; $display("[TB] FAIL rd_valid_bits: got %h want 01", vs); end
    n_compared++; if (vc !== 4) begin n_mismatched++; $display("[TB] FAIL rd_valid_cycles: got %0d want 4", vc); end
    n_compared++; if (va !== 5'd4) begin n_mismatched++; $display("[TB] FAIL rd_addr: got %0d want 4", va); end
    n_compared++; if (vr !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_rwn: got %b want 1", vr); end
    n_compared++; if (lat !== 5) begin n_mismatched++; $display("[TB] FAIL rd_latency: got %0d want 5", lat); end
  endtask

  task automatic test_decode();
    int vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    ready_wait = 0; ready_never = 1'b0;
    resp_data[7] = 32'hDEAD_BEEF;
    push_exp(32'hDEAD_BEEF, 1'b0);
    apb_xfer(12'hB8F, 32'h0, 1'b0, vc, vs, lat, va, vr, vd);
    n_compared++; if (vs !== 8'h80) begin n_mismatched++; $display("[TB] FAIL dec_valid_bits: got %h want 80", vs); end
    n_compared++; if (va !== 5'd3) begin n_mismatched++; $display("[TB] FAIL dec_addr: got %0d want 3", va); end
  endtask

  task automatic test_timeout();
    int vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    ready_never = 1'b1;
    resp_data[1] = 32'h1111_2222;
    push_exp(32'h0, 1'b1);
    apb_xfer(12'h080, 32'h0, 1'b0, vc, vs, lat, va, vr, vd);
    n_compared++; if (vs !== 8'h02) begin n_mismatched++; $display("[TB] FAIL to_valid_bits: got %h want 02", vs); end
    n_compared++; if (vc !== TO) begin n_mismatched++; $display("[TB] FAIL to_valid_cycles: got %0d want %0d", vc, TO); end
    n_compared++; if (lat !== TO + 1) begin n_mismatched++; $display("[TB] FAIL to_latency: got %0d want %0d", lat, TO + 1); end
    ready_never = 1'b0;
  endtask

  task automatic test_bad_index();
    int vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    push_exp(32'h0, 1'b1);
    apb_xfer(12'h400, 32'h1234_5678, 1'b1, vc, vs, lat, va, vr, vd);
    n_compared++; if (vc !== 0) begin n_mismatched++; $display("[TB] FAIL bad_valid_cycles: got %0d want 0", vc); end
    n_compared++; if (lat !== 1) begin n_mismatched++; $display("[TB] FAIL bad_latency: got %0d want 1", lat); end
  endtask

  task automatic test_setup_only();
    int bad = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h104; pwrite = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (cfg_valid_o != 0 || apb_pready_o) bad++;
    end
    @(posedge clk); #1;
    psel = 1'b0;
    n_compared++; if (bad !== 0) begin n_mismatched++; $display("[TB] FAIL setup_only: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_psel_drop();
    int vc = 0, lat = 0; logic dropped = 1'b0; logic [NT-1:0] vs = '0;
    ready_wait = 2;
    resp_data[5] = 32'h55AA_1234;
    push_exp(32'h55AA_1234, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h288; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      if (cfg_valid_o != 0) begin vc++; vs |= cfg_valid_o; end
      if (apb_pready_o) break;
      lat++;
      if (vc == 1 && !dropped) begin
        dropped = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
      end
    end
    n_compared++; if (vs !== 8'h20) begin n_mismatched++; $display("[TB] FAIL drop_valid_bits: got %h want 20", vs); end
    n_compared++; if (vc !== 3) begin n_mismatched++; $display("[TB] FAIL drop_valid_cycles: got %0d want 3", vc); end
    n_compared++; if (lat !== 4) begin n_mismatched++; $display("[TB] FAIL drop_latency: got %0d want 4", lat); end
    ready_wait = 0;
  endtask

  task automatic test_reset_abort();
    int pr = 0, vc, lat; logic [NT-1:0] vs; logic [4:0] va; logic vr; logic [31:0] vd;
    ready_never = 1'b1;
    push_exp(32'h0, 1'b1);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h300; pwdata = 32'hCAFE_0001; pwrite = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(negedge clk);
    n_compared++; if (cfg_valid_o !== 8'h40) begin n_mismatched++; $display("[TB] FAIL abort_pre_valid: got %h want 40", cfg_valid_o); end
    rst = 1'b1;
    #1;
    n_compared++; if (cfg_valid_o !== '0) begin n_mismatched++; $display("[TB] FAIL abort_valid: got %h want 00", cfg_valid_o); end
    sb.delete();
    psel = 1'b0; penable = 1'b0; ready_never = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (apb_pready_o) pr++;
    end
    n_compared++; if (pr !== 0) begin n_mismatched++; $display("[TB] FAIL abort_pready: got %0d pulses want 0", pr); end
    push_exp(32'h0, 1'b0);
    apb_xfer(12'h184, 32'h0BAD_F00D, 1'b1, vc, vs, lat, va, vr, vd);
    n_compared++; if (vs !== 8'h08) begin n_mismatched++; $display("[TB] FAIL post_abort_bits: got %h want 08", vs); end
    n_compared++; if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL post_abort_latency: got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0, p1 = -1, p2 = -1, v0 = 0, v7 = 0, other = 0, overlap = 0;
    ready_wait = 0; ready_never = 1'b0;
    push_exp(32'h0, 1'b0);
    push_exp(32'h0, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 12'h000; pwdata = 32'h1111_0000; pwrite = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    while (p2 < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cfg_valid_o == 8'h01) v0++;
      else if (cfg_valid_o == 8'h80) v7++;
      else if (cfg_valid_o != 0) other++;
      if (apb_pready_o && cfg_valid_o != 0) overlap++;
      if (apb_pready_o) begin
        if (p1 < 0) begin
          p1 = cyc;
          @(posedge clk); #1;
          paddr = 12'h380; pwdata = 32'h7777_0000;
        end else p2 = cyc;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    n_compared++; if (v0 !== 1) begin n_mismatched++; $display("[TB] FAIL b2b_valid_t0: got %0d want 1", v0); end
    n_compared++; if (v7 !== 1) begin n_mismatched++; $display("[TB] FAIL b2b_valid_t7: got %0d want 1", v7); end
    n_compared++; if (other !== 0 || overlap !== 0) begin n_mismatched++; $display("[TB] FAIL b2b_clean: got other=%0d overlap=%0d want 0/0", other, overlap); end
    n_compared++; if (p2 - p1 !== 3) begin n_mismatched++; $display("[TB] FAIL b2b_gap: got %0d want 3", p2 - p1); end
  endtask

  initial begin
    for (int i = 0; i < NT; i++) resp_data[i] = 32'h0;
    test_reset();
    test_write();
    test_read_wait();
    test_decode();
    test_timeout();
    test_bad_index();
    test_setup_only();
    test_psel_drop();
    test_reset_abort();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_compared++;
    if (sb.size() !== 0) begin n_mismatched++; $display("[TB] FAIL sb_pending: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
